// File: rtl/guess_entry_collector_if.sv
// Digit-entry bundle between the key pad and the guess collector.
// The master drives the raw keys; the slave returns the assembled guess and status strobes.
interface guess_entry_collector_if;
  logic [9:0]  key;
  logic [15:0] guess;
  logic [2:0]  digit_count;
  logic        guess_valid;
  logic        dup_err;
  logic        multi_err;

  modport master (
    output key,
    input  guess, digit_count, guess_valid, dup_err, multi_err
  );

  modport slave (
    input  key,
    output guess, digit_count, guess_valid, dup_err, multi_err
  );
endinterface

// File: rtl/guess_entry_collector.sv
// Debounces ten digit keys and assembles four distinct digits into a BCD guess,
// strobing guess_valid on completion and flagging duplicate or multi-key presses.
module guess_entry_collector #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [3:0] EMPTY_NIBBLE    = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst,
  guess_entry_collector_if.slave  bus
);

  localparam logic [7:0]  CNT_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] GUESS_EMPTY = {4{EMPTY_NIBBLE}};

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_FULL} state_t;

  logic [9:0] sync_p0, sync_p1;
  logic [9:0] deb, deb_d;
  logic [7:0] cnt [10];

  // Stage boundary: two-flop synchroniser, then per-key debounce counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb     <= '0;
      deb_d   <= '0;
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= bus.key;
      sync_p1 <= sync_p0;
      deb_d   <= deb;
      for (int i = 0; i < 10; i++) begin
        if (sync_p1[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  logic [9:0] press;
  logic       ev_one, ev_many;
  logic [3:0] ev_digit;

  assign press   = deb & ~deb_d;
  assign ev_one  = (press != '0) && ((press & (press - 10'd1)) == '0);
  assign ev_many = (press != '0) && !ev_one;

  always_comb begin
    ev_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (press[i]) ev_digit = 4'(i);
    end
  end

  state_t      state;
  logic [15:0] guess_q;
  logic [2:0]  count_q;
  logic        valid_q, dup_q, multi_q;
  logic        is_dup;

  // Only filled positions take part, so digit 0 never collides with an empty slot
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < count_q) && (guess_q[15 - 4*i -: 4] == ev_digit)) is_dup = 1'b1;
    end
  end

  // Stage boundary: entry FSM with registered guess, count and strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_EMPTY;
      guess_q <= GUESS_EMPTY;
      count_q <= 3'd0;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
      multi_q <= 1'b0;
      if (ev_many) begin
        multi_q <= 1'b1;
      end else if (ev_one) begin
        case (state)
          S_ENTRY: begin
            if (is_dup) begin
              dup_q <= 1'b1;
            end else begin
              case (count_q)
                3'd1:    guess_q[11:8] <= ev_digit;
                3'd2:    guess_q[7:4]  <= ev_digit;
                default: guess_q[3:0]  <= ev_digit;
              endcase
              count_q <= count_q + 3'd1;
              if (count_q == 3'd3) begin
                state   <= S_FULL;
                valid_q <= 1'b1;
              end
            end
          end
          default: begin
            // Empty or full: the press starts a fresh guess
            guess_q <= {ev_digit, EMPTY_NIBBLE, EMPTY_NIBBLE, EMPTY_NIBBLE};
            count_q <= 3'd1;
            state   <= S_ENTRY;
          end
        endcase
      end
    end
  end

  assign bus.guess       = guess_q;
  assign bus.digit_count = count_q;
  assign bus.guess_valid = valid_q;
  assign bus.dup_err     = dup_q;
  assign bus.multi_err   = multi_q;

endmodule
